// File: rtl/asi_pkg.sv
// Shared AXI slave-interface constants and the narrow-transfer byte-lane mask helper.
// Used by both the read and write backends.
package asi_pkg;
    localparam int AXI_DW = 128;
    localparam int AXI_AW = 40;
    localparam int AXI_SW = 3;

    localparam logic [1:0] BT_FIXED = 2'b00;
    localparam logic [1:0] BT_INCR  = 2'b01;
    localparam logic [1:0] BT_WRAP  = 2'b10;

    // Widest lane mask any instance can ask for (1024-bit bus); callers slice it down.
    localparam int MASK_W = 128;

    function automatic logic [MASK_W-1:0] size_to_mask(input int addr_lo, input int size,
                                                       input int nlanes);
        logic [MASK_W-1:0] m;
        int nb;
        int lo;
        m  = '0;
        nb = 1 << size;
        if (nb > nlanes) nb = nlanes;
        lo = (addr_lo % nlanes) & ~(nb - 1);
        for (int i = 0; i < MASK_W; i++)
            if (i >= lo && i < lo + nb) m[i] = 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/asi_pipe_dly.sv
// Valid + payload delay line of depth D. Only the valid bits are reset;
// payload is qualified by valid downstream.
module asi_pipe_dly #(
    parameter int W = 8,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_vld,
    input  logic [W-1:0] i_dat,
    output logic         o_vld,
    output logic [W-1:0] o_dat
);
    logic [D-1:0] r_vld;
    logic [W-1:0] r_dat [D];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_vld;
            for (int i = 1; i < D; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_dat[0] <= i_dat;
        for (int i = 1; i < D; i++) r_dat[i] <= r_dat[i-1];
    end

    assign o_vld = r_vld[D-1];
    assign o_dat = r_dat[D-1];
endmodule

// File: rtl/asi_rsram.sv
// AXI slave read backend: decodes a beat, reads the external SRAM and returns
// lane-masked data SLV_WS cycles later, with beat/burst/error statistics.
module asi_rsram
    import asi_pkg::*;
#(
    parameter int                AXI_DW    = asi_pkg::AXI_DW,
    parameter int                AXI_AW    = asi_pkg::AXI_AW,
    parameter int                AXI_SW    = asi_pkg::AXI_SW,
    parameter int                SLV_WS    = 2,
    parameter logic [AXI_AW-1:0] MEM_BASE  = '0,
    parameter int                MEM_DEPTH = 1024,
    localparam int               SLV_BYTES = AXI_DW / 8,
    localparam int               MEM_AW    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_re,
    input  logic [AXI_AW-1:0] m_raddr,
    input  logic [AXI_SW-1:0] m_rsize,
    input  logic              m_rlast,
    output logic [AXI_DW-1:0] m_rdata,
    output logic              m_rvalid,
    output logic              m_rslverr,
    output logic              sram_ce,
    output logic [MEM_AW-1:0] sram_addr,
    input  logic [AXI_DW-1:0] sram_q,
    output logic [31:0]       stat_beats,
    output logic [31:0]       stat_bursts,
    output logic [15:0]       stat_errs
);
    localparam int LB = $clog2(SLV_BYTES);
    localparam logic [AXI_AW:0] MEM_BYTES = (AXI_AW+1)'(MEM_DEPTH) << LB;
    localparam int SB_W = 2 + SLV_BYTES;

    logic [AXI_AW-1:0]    w_off;
    logic                 w_err;
    logic [SLV_BYTES-1:0] w_mask;

    assign w_off  = m_raddr - MEM_BASE;
    assign w_err  = (m_raddr < MEM_BASE) || ({1'b0, w_off} >= MEM_BYTES)
                 || (m_rsize > AXI_SW'(LB));
    assign w_mask = SLV_BYTES'(size_to_mask(int'(m_raddr[LB-1:0]), int'(m_rsize), SLV_BYTES));

    assign sram_ce   = m_re & ~w_err;
    assign sram_addr = w_off[MEM_AW+LB-1:LB];

    // Stage 1: sidebands registered so they line up with sram_q.
    logic                 w_v1, w_e1, w_l1;
    logic [SLV_BYTES-1:0] w_m1;
    logic [AXI_DW-1:0]    w_emask, w_d1;

    asi_pipe_dly #(.W(SB_W), .D(1)) u_sb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_vld (m_re),
        .i_dat ({w_err, m_rlast, w_mask}),
        .o_vld (w_v1),
        .o_dat ({w_e1, w_l1, w_m1})
    );

    for (genvar b = 0; b < SLV_BYTES; b++) begin : g_lane
        assign w_emask[b*8 +: 8] = {8{w_m1[b]}};
    end
    assign w_d1 = w_e1 ? '0 : (sram_q & w_emask);

    logic              w_ov, w_oerr, w_olast;
    logic [AXI_DW-1:0] w_odata;

    if (SLV_WS == 1) begin : g_ws1
        assign w_ov    = w_v1;
        assign w_oerr  = w_v1 & w_e1;
        assign w_olast = w_v1 & w_l1;
        assign w_odata = w_v1 ? w_d1 : '0;
    end else begin : g_wsn
        logic              w_v2, w_e2, w_l2;
        logic [AXI_DW-1:0] w_d2;
        logic              r_rvalid, r_rslverr, r_rlast;
        logic [AXI_DW-1:0] r_rdata;

        if (SLV_WS == 3) begin : g_mid
            asi_pipe_dly #(.W(2 + AXI_DW), .D(1)) u_mid (
                .clk   (clk),
                .rst_n (rst_n),
                .i_vld (w_v1),
                .i_dat ({w_e1, w_l1, w_d1}),
                .o_vld (w_v2),
                .o_dat ({w_e2, w_l2, w_d2})
            );
        end else begin : g_nomid
            assign {w_v2, w_e2, w_l2, w_d2} = {w_v1, w_e1, w_l1, w_d1};
        end

        // Output register is the only data stage with a reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rvalid  <= 1'b0;
                r_rslverr <= 1'b0;
                r_rlast   <= 1'b0;
                r_rdata   <= '0;
            end else begin
                r_rvalid  <= w_v2;
                r_rslverr <= w_v2 & w_e2;
                r_rlast   <= w_v2 & w_l2;
                r_rdata   <= w_v2 ? w_d2 : '0;
            end
        end

        assign w_ov    = r_rvalid;
        assign w_oerr  = r_rslverr;
        assign w_olast = r_rlast;
        assign w_odata = r_rdata;
    end

    assign m_rvalid  = w_ov;
    assign m_rslverr = w_oerr;
    assign m_rdata   = w_odata;

    logic [31:0] r_beats, r_bursts;
    logic [15:0] r_errs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beats  <= '0;
            r_bursts <= '0;
            r_errs   <= '0;
        end else if (w_ov) begin
            r_beats <= r_beats + 32'd1;
            if (w_olast) r_bursts <= r_bursts + 32'd1;
            if (w_oerr && r_errs != 16'hFFFF) r_errs <= r_errs + 16'd1;
        end
    end

    assign stat_beats  = r_beats;
    assign stat_bursts = r_bursts;
    assign stat_errs   = r_errs;
endmodule

// File: tb/tb_asi_rsram.sv
// Directed bench for asi_rsram (SLV_WS=2, 128-bit, base 0x1000) with a behavioural SRAM.
module tb_asi_rsram;
    localparam int DW = 128, AW = 40, SW = 3, WS = 2, DEPTH = 1024, MAW = 10;
    localparam logic [AW-1:0] BASE = 40'h1000;

    logic           clk = 1'b0, rst_n = 1'b0;
    logic           m_re = 1'b0, m_rlast = 1'b0;
    logic [AW-1:0]  m_raddr = '0;
    logic [SW-1:0]  m_rsize = '0;
    logic [DW-1:0]  m_rdata, sram_q = '0;
    logic           m_rvalid, m_rslverr, sram_ce;
    logic [MAW-1:0] sram_addr;
    logic [31:0]    stat_beats, stat_bursts;
    logic [15:0]    stat_errs;

    logic [DW-1:0] mem [DEPTH];
    int n_chk = 0, n_bad = 0;

    asi_rsram #(.AXI_DW(DW), .AXI_AW(AW), .AXI_SW(SW), .SLV_WS(WS),
                .MEM_BASE(BASE), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .m_re(m_re), .m_raddr(m_raddr), .m_rsize(m_rsize),
        .m_rlast(m_rlast), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rslverr(m_rslverr),
        .sram_ce(sram_ce), .sram_addr(sram_addr), .sram_q(sram_q),
        .stat_beats(stat_beats), .stat_bursts(stat_bursts), .stat_errs(stat_errs));

    always #5 clk = ~clk;
    always @(posedge clk) if (sram_ce) sram_q <= mem[sram_addr];

    function automatic logic [DW-1:0] pat(input int i);
        return {4{32'(i) * 32'h0100_0193 + 32'h9e37_79b9}};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One isolated beat: checks SRAM strobe, latency, data, error, single-cycle valid.
    task automatic rd1(input string tag, input logic [AW-1:0] a, input logic [SW-1:0] sz,
                       input logic last, input logic exp_ce, input int exp_wa,
                       input logic [DW-1:0] exp_d, input logic exp_e);
        int lat;
        @(negedge clk);
        m_re = 1'b1; m_raddr = a; m_rsize = sz; m_rlast = last;
        #1;
        chk({tag, ".ce"}, DW'(sram_ce), DW'(exp_ce));
        if (exp_ce) chk({tag, ".wa"}, DW'(sram_addr), DW'(exp_wa));
        @(negedge clk);
        m_re = 1'b0; m_rlast = 1'b0;
        lat = 1;
        while (!m_rvalid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, DW'(lat), DW'(WS));
        chk({tag, ".data"}, m_rdata, exp_d);
        chk({tag, ".err"}, DW'(m_rslverr), DW'(exp_e));
        @(negedge clk);
        chk({tag, ".one"}, DW'(m_rvalid), '0);
    endtask

    initial begin
        logic [DW-1:0] a5, w0, top;
        for (int i = 0; i < DEPTH; i++) mem[i] = pat(i);
        for (int b = 0; b < 16; b++) mem[0][b*8 +: 8] = 8'(b);
        mem[1] = {16{8'hA5}};
        a5  = {16{8'hA5}};
        w0  = mem[0];
        top = pat(1023);

        #12;
        chk("rst.valid", DW'(m_rvalid), '0);
        chk("rst.data", m_rdata, '0);
        chk("rst.stats", {stat_beats, stat_bursts, stat_errs}, '0);
        @(negedge clk); rst_n = 1'b1;

        rd1("full",   40'h1010, 3'd4, 1'b1, 1'b1, 1, a5, 1'b0);
        rd1("half",   40'h1006, 3'd1, 1'b0, 1'b1, 0, 128'h0706 << 48, 1'b0);
        rd1("byte",   40'h100F, 3'd0, 1'b0, 1'b1, 0, 128'h0f << 120, 1'b0);
        rd1("word",   40'h100D, 3'd2, 1'b0, 1'b1, 0, w0 & (128'hffff_ffff << 96), 1'b0);
        rd1("lo_err", 40'h0FF0, 3'd4, 1'b0, 1'b0, 0, '0, 1'b1);
        rd1("hi_err", 40'h5000, 3'd4, 1'b0, 1'b0, 0, '0, 1'b1);
        rd1("sz_err", 40'h1000, 3'd5, 1'b1, 1'b0, 0, '0, 1'b1);
        rd1("top",    40'h4FF0, 3'd4, 1'b0, 1'b1, 1023, top, 1'b0);
        rd1("topb",   40'h4FFF, 3'd0, 1'b0, 1'b1, 1023, top & (128'hff << 120), 1'b0);
        chk("st.beats", DW'(stat_beats), DW'(9));
        chk("st.bursts", DW'(stat_bursts), DW'(2));
        chk("st.errs", DW'(stat_errs), DW'(3));

        // Reset with two beats in flight.
        @(negedge clk); m_re = 1'b1; m_raddr = 40'h1000; m_rsize = 3'd4;
        @(negedge clk); m_raddr = 40'h1010;
        @(negedge clk); m_re = 1'b0; rst_n = 1'b0;
        #1;
        chk("mid.valid", DW'(m_rvalid), '0);
        chk("mid.stats", {stat_beats, stat_bursts, stat_errs}, '0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("mid.quiet%0d", k), DW'(m_rvalid), '0);
        end

        // 16-beat streaming burst starting at word 2.
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            chk($sformatf("bst.v%0d", k), DW'(m_rvalid), DW'(k >= 2));
            if (k >= 2) chk($sformatf("bst.d%0d", k - 2), m_rdata, pat(k));
            if (k < 16) begin
                m_re = 1'b1; m_raddr = BASE + 40'(32 + 16 * k);
                m_rsize = 3'd4; m_rlast = (k == 15);
            end else begin
                m_re = 1'b0; m_rlast = 1'b0;
            end
        end
        @(negedge clk); @(negedge clk);
        chk("bst.beats", DW'(stat_beats), DW'(16));
        chk("bst.bursts", DW'(stat_bursts), DW'(1));
        chk("bst.errs", DW'(stat_errs), '0);

        rd1("post", 40'h1010, 3'd4, 1'b0, 1'b1, 1, a5, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/asi_rsram.md
# asi_rsram

Read backend for the AXI slave interface, in the usr_clk domain directly downstream of the read-channel interface. It accepts one beat request per cycle (m_re, m_raddr, m_rsize), reads a single-port synchronous SRAM and returns m_rdata/m_rvalid/m_rslverr exactly SLV_WS cycles after the request. It masks inactive byte lanes for narrow transfers, flags out-of-range addresses, and keeps beat and burst statistics.

## Interface
- AXI_DW, 128, data width; power of two, ≥ 16.
- AXI_AW, 40, address width.
- AXI_SW, 3, size field width.
- SLV_WS, 2, request→data latency in cycles; legal range 1..3, which the upstream almost-full margin of 4 requires.
- MEM_BASE, 0, byte base address; aligned to AXI_DW/8.
- MEM_DEPTH, 1024, SRAM depth in AXI_DW words; power of two.
- Derived: SLV_BYTES = AXI_DW/8, MEM_AW = $clog2(MEM_DEPTH).
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- m_re  in  1  beat request.
- m_raddr  in  AXI_AW  byte address of the beat.
- m_rsize  in  AXI_SW  beat size, log2 bytes.
- m_rlast  in  1  last beat of the burst.
- m_rdata  out  AXI_DW  read data with inactive lanes zeroed.
- m_rvalid  out  1  data valid.
- m_rslverr  out  1  slave error, qualified by m_rvalid.
- sram_ce  out  1  SRAM read enable.
- sram_addr  out  MEM_AW  SRAM word address.
- sram_q  in  AXI_DW  SRAM output, valid 1 cycle after sram_ce.
- stat_beats  out  32  count of returned beats.
- stat_bursts  out  32  count of returned last beats.
- stat_errs  out  16  count of error beats, saturating.

## Operation
- No backpressure. Every m_re cycle produces exactly one m_rvalid pulse SLV_WS cycles later. Back-to-back requests give back-to-back responses in order.
- Decode on the m_re cycle, with off = m_raddr − MEM_BASE:
  - in_range = m_raddr ≥ MEM_BASE and off < MEM_DEPTH·SLV_BYTES.
  - size_err = m_rsize > log2(SLV_BYTES).
  - err = !in_range or size_err.
- sram_ce = m_re & !err, combinational. sram_addr = off[MEM_AW+log2(SLV_BYTES)-1 : log2(SLV_BYTES)]. An errored beat does not touch the SRAM.
- Lane mask, valid only when !err:
  - nbytes = 1<<m_rsize; lo = m_raddr mod SLV_BYTES rounded down to a multiple of nbytes.
  - Bytes lo..lo+nbytes−1 are active.
  - A full-width size gives all ones.
- Pipeline: a valid shift register of depth SLV_WS carries {valid, err, mask}.
  - Stage 1 holds the registered sram_q.
  - Stages 2..SLV_WS only delay.
  - At the output: m_rdata = err ? 0 : (data & expanded mask); m_rslverr = err.
- Statistics update on the output cycle.
  - stat_beats += 1 on each m_rvalid; stat_bursts += 1 when m_rvalid and the delayed m_rlast; both wrap modulo 2^32.
  - stat_errs += 1 on m_rvalid & m_rslverr; it saturates at 0xFFFF.

## Timing
- Request at cycle t: sram_ce at t; sram_q at t+1; m_rvalid/m_rdata/m_rslverr registered outputs at t+SLV_WS.
- For SLV_WS = 1, m_rdata is driven from sram_q via the mask. The valid, err and mask sidebands are still registered.
- Reset, asynchronous:
  - m_rvalid = 0, m_rslverr = 0, m_rdata = 0, and all stat_* = 0.
  - The valid pipeline clears.
  - Data stages are not reset except the output register.
- Reset mid-operation: in-flight beats are discarded and no m_rvalid pulse follows reset release.
- m_rlast with m_re = 0 is ignored. m_raddr and m_rsize are don't-care when m_re = 0.
- A beat that is both in error and last still increments stat_bursts.

## Structure
- Shared package asi_pkg: AXI_* width defaults, BT_* burst constants, and a function size_to_mask(addr_lo, size), which is shared with the write backend.
- One sub-module, asi_pipe_dly (parameter W and depth D, valid plus payload shift register, async reset on valid only). It is reused by the write backend.
- The SRAM is external; its macro is not instantiated here.

## Test plan
- SLV_WS=2, DW=128, MEM_BASE=0x1000; m_re at addr 0x1010, size 4; SRAM word 1 = 0xA5 repeated → sram_addr=1 at t; m_rvalid at t+2; m_rdata=all 0xA5; m_rslverr=0.
- Narrow: addr 0x1006, size 1, word 0 = byte i holds i → m_rdata has bytes 6..7 = 0x06, 0x07 and all others 0.
- Range error: addr 0x0FF0, then addr 0x1000+1024·16 → sram_ce=0 for both; two m_rvalid with m_rslverr=1 and m_rdata=0; stat_errs=2.
- Size error: size 5 at addr 0x1000 → m_rslverr=1 and no SRAM access.
- Streaming burst of 16 beats: m_re held 16 cycles, m_rlast on beat 16 → 16 consecutive m_rvalid; stat_beats=16; stat_bursts=1.
- Reset asserted while 2 beats are in flight → no m_rvalid after release; stats = 0; the next request returns correctly at +SLV_WS.
